instr_queue: RTL and testbench
==============================

# instr_queue

Decoded-instruction FIFO between decode and the Tomasulo issue point. Buffers up to DEPTH decoded instructions, then issues the head in order: one ROB allocation plus one reservation-station load in the same cycle. Issue waits for a free ROB slot and a free slot in the target station. On a branch mispredict the queue is emptied and the ROB-tag counter is resynchronised.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- PTR_W, $clog2(DEPTH), pointer width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  queue can accept; equals !(count == DEPTH)
- in_op  in  tomasula_types::op_t  operation class (ALU, LD, ST, BRANCH)
- in_rd  in  5  destination register
- in_rs1, in_rs2  in  5 each  source registers
- in_st_src  in  5  store-data register (ST only)
- in_imm  in  32  immediate
- rob_full  in  1  ROB cannot accept
- rs_full_alu, rs_full_mem, rs_full_br  in  1 each  station full
- branch_mispredict  in  1  flush request
- flush_tag  in  3  ROB tag the next issued instruction must receive after a flush
- rob_load  out  1  issue strobe to ROB
- instr_type  out  tomasula_types::op_t  head op
- rd, st_src  out  5 each  head rd / st_src
- rs_load_alu, rs_load_mem, rs_load_br  out  1 each  issue strobe to station
- issue_rs1, issue_rs2  out  5 each  head sources
- issue_imm  out  32  head immediate
- issue_tag  out  3  ROB tag assigned to the issuing instruction
- iq_count  out  PTR_W+1  occupancy

## Operation
- Storage: circular buffer with head_ptr and tail_ptr (PTR_W bits, natural wrap) and count (PTR_W+1 bits). Empty when count == 0. Full when count == DEPTH.
- Enqueue fires on in_valid && in_ready && !branch_mispredict && !rst. The entry is written at tail_ptr, and tail_ptr increments.
- in_ready depends only on count. A full queue refuses enqueue even in a cycle where it dequeues.
- Target station: LD/ST → mem, BRANCH → br, everything else → alu. tgt_full is the rs_full_* of the target station.
- issue = !empty && !rob_full && !tgt_full && !branch_mispredict && !rst.
- rob_load = issue. Exactly one rs_load_* equals issue (the target one); the others are 0.
- Data outputs (instr_type, rd, st_src, issue_rs1/rs2/imm) are driven combinationally from the head entry whenever the queue is non-empty. They are don't-care when empty.
- issue_tag is driven from the tag_ctr register.
- On issue: head_ptr increments and tag_ctr increments (3-bit wrap, 7 → 0).
- count update: +1 on enqueue only, −1 on issue only, unchanged when both or neither occur.
- Flush (branch_mispredict = 1): head_ptr, tail_ptr and count go to 0 and tag_ctr ← flush_tag. No issue and no enqueue that cycle. Flush has priority over everything except rst.
- A flush while empty or full behaves identically.
- No state machine beyond pointers and count. rst and flush are the only discontinuities.

## Timing
- Reset values: count = 0, head_ptr = tail_ptr = 0, tag_ctr = 0. Therefore in_ready = 1, rob_load = 0, all rs_load_* = 0, issue_tag = 0, iq_count = 0.
- Reset mid-operation discards all entries with no issue in the rst cycle.
- Enqueue-to-issue latency: minimum 1 cycle. An entry written at edge N can issue in the cycle after edge N. There is no same-cycle bypass from in_* to the issue outputs.
- Issue strobes are combinational single-cycle pulses. The ROB and stations sample them at the same posedge at which the queue pops.
- Throughput: one enqueue and one issue per cycle.
- Stall is lossless. The head and its issue_tag hold stable while rob_full or tgt_full stays high.
- rob_full, rs_full_* and branch_mispredict feed the issue outputs combinationally. They must come from registered sources in their owning blocks.

## Test plan
- Reset, then enqueue ALU (rd = 5) with rob_full = 0 → next cycle rob_load = 1, rs_load_alu = 1, rd = 5, issue_tag = 0. Following cycle iq_count = 0, issue_tag = 1.
- Hold rob_full = 1 and enqueue 8 instructions → iq_count = 8, in_ready = 0. A 9th in_valid is ignored. Drop rob_full → 8 issues on consecutive cycles with issue_tag 0..7 in order, and in_ready = 1 after the first.
- Enqueue LD, ST, BRANCH, ALU with rs_full_mem = 1 → no issue. Release rs_full_mem → rs_load_mem pulses twice (LD, then ST with st_src correct), then rs_load_br, then rs_load_alu.
- Queue holds 4 entries, assert branch_mispredict with flush_tag = 3 and in_valid = 1 → no issue that cycle, then iq_count = 0. The next enqueued instruction issues with issue_tag = 3.
- Steady state with iq_count = 3, simultaneous enqueue and issue for 10 cycles → iq_count stays 3, pointers wrap past DEPTH−1 correctly, and tag_ctr wraps 7 → 0.
- Assert rst with 5 entries queued and issue otherwise possible → rob_load = 0 during rst. Afterwards iq_count = 0 and issue_tag = 0.

Source files
------------

// File: rtl/tomasula_types.sv
`default_nettype none
// ============================================================================
//  Package     : tomasula_types
//  Description : Shared types for the Tomasulo front end (operation classes).
//  Revision    : 1.0 - initial release
// ============================================================================
package tomasula_types;
    typedef enum logic [1:0] {
        OP_ALU    = 2'd0,
        OP_LD     = 2'd1,
        OP_ST     = 2'd2,
        OP_BRANCH = 2'd3
    } op_t;
endpackage
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_queue
//  Description : Decoded-instruction FIFO feeding the Tomasulo issue point.
//                Issues the head in order (ROB allocate + station load in the
//                same cycle) and empties on a branch mispredict.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_queue
    import tomasula_types::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_st_src,
    input  logic [31:0]      in_imm,
    input  logic             rob_full,
    input  logic             rs_full_alu,
    input  logic             rs_full_mem,
    input  logic             rs_full_br,
    input  logic             branch_mispredict,
    input  logic [2:0]       flush_tag,
    output logic             rob_load,
    output op_t              instr_type,
    output logic [4:0]       rd,
    output logic [4:0]       st_src,
    output logic             rs_load_alu,
    output logic             rs_load_mem,
    output logic             rs_load_br,
    output logic [4:0]       issue_rs1,
    output logic [4:0]       issue_rs2,
    output logic [31:0]      issue_imm,
    output logic [2:0]       issue_tag,
    output logic [PTR_W:0]   iq_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    // Entry storage; no reset needed, validity is tracked by count_q.
    op_t         op_mem_q  [DEPTH];
    logic [4:0]  rd_mem_q  [DEPTH];
    logic [4:0]  rs1_mem_q [DEPTH];
    logic [4:0]  rs2_mem_q [DEPTH];
    logic [4:0]  st_mem_q  [DEPTH];
    logic [31:0] imm_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [2:0]       tag_q, tag_d;

    logic w_empty;
    logic w_enq;
    logic w_issue;
    logic w_is_mem;
    logic w_is_br;
    logic w_tgt_full;

    assign w_empty    = (count_q == '0);
    assign in_ready   = (count_q != FULL_CNT);
    assign w_enq      = in_valid && in_ready && !branch_mispredict && !rst;

    assign instr_type = op_mem_q[head_q];
    assign rd         = rd_mem_q[head_q];
    assign st_src     = st_mem_q[head_q];
    assign issue_rs1  = rs1_mem_q[head_q];
    assign issue_rs2  = rs2_mem_q[head_q];
    assign issue_imm  = imm_mem_q[head_q];
    assign issue_tag  = tag_q;
    assign iq_count   = count_q;

    assign w_is_mem   = (instr_type == OP_LD) || (instr_type == OP_ST);
    assign w_is_br    = (instr_type == OP_BRANCH);
    assign w_tgt_full = w_is_mem ? rs_full_mem : (w_is_br ? rs_full_br : rs_full_alu);
    assign w_issue    = !w_empty && !rob_full && !w_tgt_full && !branch_mispredict && !rst;

    assign rob_load    = w_issue;
    assign rs_load_mem = w_issue && w_is_mem;
    assign rs_load_br  = w_issue && w_is_br;
    assign rs_load_alu = w_issue && !w_is_mem && !w_is_br;

    // Write the incoming instruction at the tail slot.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            op_mem_q[tail_q]  <= in_op;
            rd_mem_q[tail_q]  <= in_rd;
            rs1_mem_q[tail_q] <= in_rs1;
            rs2_mem_q[tail_q] <= in_rs2;
            st_mem_q[tail_q]  <= in_st_src;
            imm_mem_q[tail_q] <= in_imm;
        end
    end

    // Pointer, occupancy and tag next-state; a flush overrides push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        tag_d   = tag_q;
        if (branch_mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            tag_d   = flush_tag;
        end else begin
            if (w_issue) begin
                head_d = head_q + PTR_W'(1);
                tag_d  = tag_q + 3'd1;
            end
            if (w_enq) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({w_enq, w_issue})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            tag_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tag_q   <= tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_queue
//  Description : Self-checking bench for instr_queue: directed scenarios with
//                literal expectations plus randomized traffic against a
//                queue-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_queue;
    import tomasula_types::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    op_t              in_op;
    logic [4:0]       in_rd, in_rs1, in_rs2, in_st_src;
    logic [31:0]      in_imm;
    logic             rob_full, rs_full_alu, rs_full_mem, rs_full_br;
    logic             branch_mispredict;
    logic [2:0]       flush_tag;
    logic             rob_load;
    op_t              instr_type;
    logic [4:0]       rd, st_src, issue_rs1, issue_rs2;
    logic             rs_load_alu, rs_load_mem, rs_load_br;
    logic [31:0]      issue_imm;
    logic [2:0]       issue_tag;
    logic [PTR_W:0]   iq_count;

    int checks   = 0;
    int failures = 0;

    instr_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_st_src(in_st_src), .in_imm(in_imm),
        .rob_full(rob_full), .rs_full_alu(rs_full_alu),
        .rs_full_mem(rs_full_mem), .rs_full_br(rs_full_br),
        .branch_mispredict(branch_mispredict), .flush_tag(flush_tag),
        .rob_load(rob_load), .instr_type(instr_type), .rd(rd), .st_src(st_src),
        .rs_load_alu(rs_load_alu), .rs_load_mem(rs_load_mem), .rs_load_br(rs_load_br),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_imm(issue_imm),
        .issue_tag(issue_tag), .iq_count(iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        op_t         op;
        logic [4:0]  rd, rs1, rs2, st;
        logic [31:0] imm;
    } ent_t;

    ent_t mq[$];
    int   mtag  = 0;
    bit   armed = 0;

    // Compare every cycle at negedge, then advance the model by the coming edge.
    always @(negedge clk) begin
        ent_t h;
        ent_t e;
        bit   empty, tf, exp_issue, is_mem, is_br;
        empty = (mq.size() == 0);
        tf = 1'b0; is_mem = 1'b0; is_br = 1'b0;
        if (!empty) begin
            h = mq[0];
            is_mem = (h.op == OP_LD) || (h.op == OP_ST);
            is_br  = (h.op == OP_BRANCH);
            tf = is_mem ? rs_full_mem : (is_br ? rs_full_br : rs_full_alu);
        end
        exp_issue = !empty && !rob_full && !tf && !branch_mispredict && !rst;
        if (armed) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, mq.size() != DEPTH});
            chk("iq_count", {28'b0, iq_count}, mq.size());
            chk("issue_tag", {29'b0, issue_tag}, mtag);
            chk("rob_load", {31'b0, rob_load}, {31'b0, exp_issue});
            chk("rs_load_mem", {31'b0, rs_load_mem}, {31'b0, exp_issue && is_mem});
            chk("rs_load_br", {31'b0, rs_load_br}, {31'b0, exp_issue && is_br});
            chk("rs_load_alu", {31'b0, rs_load_alu}, {31'b0, exp_issue && !is_mem && !is_br});
            if (!empty) begin
                chk("instr_type", {30'b0, instr_type}, {30'b0, h.op});
                chk("rd", {27'b0, rd}, {27'b0, h.rd});
                chk("st_src", {27'b0, st_src}, {27'b0, h.st});
                chk("issue_rs1", {27'b0, issue_rs1}, {27'b0, h.rs1});
                chk("issue_rs2", {27'b0, issue_rs2}, {27'b0, h.rs2});
                chk("issue_imm", issue_imm, h.imm);
            end
        end
        if (rst) begin
            mq.delete();
            mtag  = 0;
            armed = 1;
        end else if (armed) begin
            if (branch_mispredict) begin
                mq.delete();
                mtag = flush_tag;
            end else begin
                bit can_enq;
                can_enq = in_valid && (mq.size() != DEPTH);
                if (exp_issue) begin
                    void'(mq.pop_front());
                    mtag = (mtag + 1) % 8;
                end
                if (can_enq) begin
                    e.op = in_op; e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2;
                    e.st = in_st_src; e.imm = in_imm;
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_op = OP_ALU; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
        in_st_src = 0; in_imm = 0; rob_full = 0; rs_full_alu = 0;
        rs_full_mem = 0; rs_full_br = 0; branch_mispredict = 0; flush_tag = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic enq(input op_t op, input logic [4:0] r, input logic [4:0] s);
        in_valid  = 1; in_op = op; in_rd = r; in_st_src = s;
        in_rs1    = 5'($urandom); in_rs2 = 5'($urandom); in_imm = $urandom;
        step();
        in_valid  = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;

        // Single ALU through an empty queue.
        in_valid = 1; in_op = OP_ALU; in_rd = 5;
        @(negedge clk);
        chk("t1_ready", {31'b0, in_ready}, 1);
        chk("t1_cnt0", {28'b0, iq_count}, 0);
        chk("t1_tag0", {29'b0, issue_tag}, 0);
        chk("t1_noload", {31'b0, rob_load}, 0);
        step();
        in_valid = 0;
        @(negedge clk);
        chk("t1_robload", {31'b0, rob_load}, 1);
        chk("t1_rsalu", {31'b0, rs_load_alu}, 1);
        chk("t1_rd", {27'b0, rd}, 5);
        chk("t1_tag", {29'b0, issue_tag}, 0);
        step();
        @(negedge clk);
        chk("t1_cnt", {28'b0, iq_count}, 0);
        chk("t1_tag1", {29'b0, issue_tag}, 1);
        step();

        // Fill to full under ROB stall, then drain.
        do_reset();
        rob_full = 1;
        for (int i = 0; i < 8; i++) enq(OP_ALU, 5'(i + 1), 0);
        in_valid = 1; in_rd = 31;
        @(negedge clk);
        chk("t2_full_cnt", {28'b0, iq_count}, 8);
        chk("t2_not_ready", {31'b0, in_ready}, 0);
        chk("t2_stall", {31'b0, rob_load}, 0);
        step();
        in_valid = 0; rob_full = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_load", {31'b0, rob_load}, 1);
            chk("t2_tag", {29'b0, issue_tag}, k);
            chk("t2_rd", {27'b0, rd}, k + 1);
            if (k >= 1) chk("t2_ready", {31'b0, in_ready}, 1);
            step();
        end
        @(negedge clk);
        chk("t2_drained", {28'b0, iq_count}, 0);
        step();

        // Station routing with the memory station stalled.
        do_reset();
        rs_full_mem = 1;
        enq(OP_LD, 1, 0);
        enq(OP_ST, 2, 7);
        enq(OP_BRANCH, 3, 0);
        enq(OP_ALU, 4, 0);
        @(negedge clk);
        chk("t3_blocked", {31'b0, rob_load}, 0);
        chk("t3_cnt", {28'b0, iq_count}, 4);
        step();
        rs_full_mem = 0;
        @(negedge clk);
        chk("t3_ld_mem", {31'b0, rs_load_mem}, 1);
        chk("t3_ld_type", {30'b0, instr_type}, {30'b0, OP_LD});
        step();
        @(negedge clk);
        chk("t3_st_mem", {31'b0, rs_load_mem}, 1);
        chk("t3_st_src", {27'b0, st_src}, 7);
        step();
        @(negedge clk);
        chk("t3_br", {31'b0, rs_load_br}, 1);
        step();
        @(negedge clk);
        chk("t3_alu", {31'b0, rs_load_alu}, 1);
        chk("t3_alu_rd", {27'b0, rd}, 4);
        step();

        // Flush with 4 queued entries and a concurrent in_valid.
        do_reset();
        rob_full = 1;
        for (int i = 0; i < 4; i++) enq(OP_ALU, 5'(i + 1), 0);
        rob_full = 0; branch_mispredict = 1; flush_tag = 3; in_valid = 1; in_rd = 20;
        @(negedge clk);
        chk("t4_noissue", {31'b0, rob_load}, 0);
        step();
        branch_mispredict = 0; in_valid = 0;
        @(negedge clk);
        chk("t4_empty", {28'b0, iq_count}, 0);
        step();
        enq(OP_ALU, 9, 0);
        @(negedge clk);
        chk("t4_load", {31'b0, rob_load}, 1);
        chk("t4_tag", {29'b0, issue_tag}, 3);
        step();

        // Steady state push+pop with wrap.
        do_reset();
        rob_full = 1;
        for (int i = 0; i < 3; i++) enq(OP_ALU, 5'(i + 1), 0);
        rob_full = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_op = OP_ALU; in_rd = 5'(10 + i);
            @(negedge clk);
            chk("t5_cnt", {28'b0, iq_count}, 3);
            chk("t5_load", {31'b0, rob_load}, 1);
            chk("t5_tag", {29'b0, issue_tag}, i % 8);
            step();
        end
        in_valid = 0;

        // Reset with a non-empty, issuable queue.
        do_reset();
        rob_full = 1;
        for (int i = 0; i < 5; i++) enq(OP_ALU, 5'(i + 1), 0);
        rob_full = 0; rst = 1;
        @(negedge clk);
        chk("t6_rst_noload", {31'b0, rob_load}, 0);
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_cnt", {28'b0, iq_count}, 0);
        chk("t6_tag", {29'b0, issue_tag}, 0);
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 199) == 0);
            in_valid          = ($urandom_range(0, 9) < 7);
            in_op             = op_t'($urandom_range(0, 3));
            in_rd             = 5'($urandom);
            in_rs1            = 5'($urandom);
            in_rs2            = 5'($urandom);
            in_st_src         = 5'($urandom);
            in_imm            = $urandom;
            rob_full          = ($urandom_range(0, 9) < 3);
            rs_full_alu       = ($urandom_range(0, 9) < 2);
            rs_full_mem       = ($urandom_range(0, 9) < 2);
            rs_full_br        = ($urandom_range(0, 9) < 2);
            branch_mispredict = ($urandom_range(0, 49) == 0);
            flush_tag         = 3'($urandom);
            step();
        end
        idle_inputs();
        rst = 0;
        repeat (12) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
